// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - physical register free list, two release ports, one allocate port
module phys_reg_free_list #(
   parameter int PREG_W   = 6,
   parameter int NUM_PREG = 64,
   parameter int NUM_AREG = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic [PREG_W-1:0] alloc_preg,
   output logic              alloc_valid,
   output logic              stall,
   input  logic              free_valid_0,
   input  logic [PREG_W-1:0] free_preg_0,
   input  logic              free_valid_1,
   input  logic [PREG_W-1:0] free_preg_1,
   output logic [PREG_W:0]   free_count,
   output logic              overflow
);

   // Tags not mapped to an architectural register at reset are the initial free pool.
   localparam int FREE_INIT = NUM_PREG - NUM_AREG;
   localparam logic [PREG_W+1:0] DEPTH = (PREG_W+2)'(NUM_PREG);

   logic [PREG_W-1:0] mem [NUM_PREG];
   logic [PREG_W-1:0] head;
   logic [PREG_W-1:0] tail;
   logic [PREG_W:0]   count;
   logic              ovf_q;

   logic              pop;
   logic              qual_0;
   logic              qual_1;
   logic              acc_0;
   logic              acc_1;
   logic              drop;
   logic [PREG_W+1:0] base;
   logic [PREG_W+1:0] room;
   logic [1:0]        n_push;
   logic [PREG_W-1:0] wr_ptr_1;

   // Pointer advance modulo NUM_PREG, so non-power-of-two depths wrap correctly.
   function automatic logic [PREG_W-1:0] ptr_add(input logic [PREG_W-1:0] p, input logic [1:0] n);
      logic [PREG_W+1:0] s;
      s = {2'b00, p} + {{PREG_W{1'b0}}, n};
      if (s >= DEPTH) begin
         s = s - DEPTH;
      end
      return PREG_W'(s);
   endfunction

   // Pop and push acceptance; the same-cycle pop frees a slot before capacity is checked,
   // and when only one slot remains port 0 wins it.
   always_comb begin
      pop      = alloc_req && (count != '0);
      qual_0   = free_valid_0 && (free_preg_0 != '0);
      qual_1   = free_valid_1 && (free_preg_1 != '0);
      base     = {1'b0, count} - {{(PREG_W+1){1'b0}}, pop};
      room     = DEPTH - base;
      acc_0    = qual_0 && (room != '0);
      acc_1    = qual_1 && (room >= (acc_0 ? (PREG_W+2)'(2) : (PREG_W+2)'(1)));
      drop     = (qual_0 && !acc_0) || (qual_1 && !acc_1);
      n_push   = {1'b0, acc_0} + {1'b0, acc_1};
      wr_ptr_1 = acc_0 ? ptr_add(tail, 2'd1) : tail;
   end

   // FIFO state: reset reloads the initial free pool, otherwise pushes and pop update independently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREG; i++) begin
            if (i < FREE_INIT) begin
               mem[i] <= PREG_W'(NUM_AREG + i);
            end else begin
               mem[i] <= '0;
            end
         end
         head  <= '0;
         tail  <= PREG_W'(FREE_INIT);
         count <= (PREG_W+1)'(FREE_INIT);
         ovf_q <= 1'b0;
      end else begin
         if (acc_0) begin
            mem[tail] <= free_preg_0;
         end
         if (acc_1) begin
            mem[wr_ptr_1] <= free_preg_1;
         end
         if (pop) begin
            head <= ptr_add(head, 2'd1);
         end
         tail  <= ptr_add(tail, n_push);
         count <= count + (PREG_W+1)'(n_push) - (PREG_W+1)'(pop);
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Outputs come from registered state only; stall alone also looks at alloc_req.
   always_comb begin
      alloc_preg  = mem[head];
      alloc_valid = (count != '0);
      stall       = alloc_req && (count == '0);
      free_count  = count;
      overflow    = ovf_q;
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed scoreboard bench for phys_reg_free_list
module tb_phys_reg_free_list;

   logic       clk;
   logic       rst;
   logic       alloc_req;
   logic [5:0] alloc_preg;
   logic       alloc_valid;
   logic       stall;
   logic       free_valid_0;
   logic [5:0] free_preg_0;
   logic       free_valid_1;
   logic [5:0] free_preg_1;
   logic [6:0] free_count;
   logic       overflow;

   int vectors;
   int miscompares;
   logic [5:0] sb[$];
   logic       ovf_m;

   phys_reg_free_list #(.PREG_W(6), .NUM_PREG(64), .NUM_AREG(32)) dut (
      .clk(clk),
      .rst(rst),
      .alloc_req(alloc_req),
      .alloc_preg(alloc_preg),
      .alloc_valid(alloc_valid),
      .stall(stall),
      .free_valid_0(free_valid_0),
      .free_preg_0(free_preg_0),
      .free_valid_1(free_valid_1),
      .free_preg_1(free_preg_1),
      .free_count(free_count),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      for (int i = 32; i < 64; i++) sb.push_back(6'(i));
      ovf_m = 1'b0;
   endtask

   task automatic check_defaults(input string tag);
      chk({tag, "_preg"},  32'(alloc_preg), 32);
      chk({tag, "_count"}, 32'(free_count), 32);
      chk({tag, "_valid"}, 32'(alloc_valid), 1);
      chk({tag, "_stall"}, 32'(stall), 0);
      chk({tag, "_ovf"},   32'(overflow), 0);
   endtask

   // One clock: drive at negedge, compare outputs against the scoreboard, update the model.
   task automatic cycle(input logic req, input logic v0, input logic [5:0] p0,
                        input logic v1, input logic [5:0] p1);
      logic [5:0] exp_tag;
      @(negedge clk);
      alloc_req = req; free_valid_0 = v0; free_preg_0 = p0; free_valid_1 = v1; free_preg_1 = p1;
      #1;
      chk("count", 32'(free_count), 32'(sb.size()));
      chk("valid", 32'(alloc_valid), 32'(sb.size() != 0));
      chk("stall", 32'(stall), 32'(req && sb.size() == 0));
      chk("ovf",   32'(overflow), 32'(ovf_m));
      if (req && sb.size() != 0) begin
         exp_tag = sb.pop_front();
         chk("alloc_preg", 32'(alloc_preg), 32'(exp_tag));
      end
      if (v0 && p0 != 0) begin
         if (sb.size() < 64) sb.push_back(p0); else ovf_m = 1'b1;
      end
      if (v1 && p1 != 0) begin
         if (sb.size() < 64) sb.push_back(p1); else ovf_m = 1'b1;
      end
      @(posedge clk);
   endtask

   initial begin
      logic [5:0] t;
      vectors = 0; miscompares = 0;
      alloc_req = 0; free_valid_0 = 0; free_preg_0 = 0; free_valid_1 = 0; free_preg_1 = 0;
      rst = 1'b1;
      model_reset();
      #2;
      check_defaults("in_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_defaults("post_reset");

      // Drain: 32 tags in order, then the 33rd request stalls.
      for (int i = 0; i < 33; i++) cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Dual free from empty, then port-1-only free while allocating.
      cycle(0, 1, 6'd5, 1, 6'd9);
      cycle(1, 0, 0, 1, 6'd12);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Tag 0 is never pushed.
      cycle(0, 1, 6'd0, 0, 0);
      cycle(0, 0, 0, 1, 6'd0);
      cycle(0, 0, 0, 0, 0);

      // Wrap-around: keep a few entries in flight for 100 allocate/free pairs.
      cycle(0, 1, 6'd3, 1, 6'd4);
      cycle(0, 1, 6'd6, 0, 0);
      for (int i = 0; i < 100; i++) begin
         t = 6'($urandom_range(1, 63));
         if (i % 2 == 0) cycle(1, 1, t, 0, 0);
         else            cycle(1, 0, 0, 1, t);
      end

      // Fill to 64, then overflow with and without a same-cycle pop.
      while (sb.size() < 64) begin
         if (64 - sb.size() >= 2) cycle(0, 1, 6'($urandom_range(1, 63)), 1, 6'($urandom_range(1, 63)));
         else                     cycle(0, 0, 0, 1, 6'($urandom_range(1, 63)));
      end
      cycle(0, 1, 6'd7, 1, 6'd8);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 6'd10, 1, 6'd11);
      cycle(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);

      // Asynchronous reset between edges with frees in flight.
      @(negedge clk);
      alloc_req = 0; free_valid_0 = 1; free_preg_0 = 6'd20; free_valid_1 = 1; free_preg_1 = 6'd21;
      #2;
      rst = 1'b1;
      #1;
      check_defaults("async_reset");
      model_reset();
      @(negedge clk);
      free_valid_0 = 0; free_valid_1 = 0;
      rst = 1'b0;
      #1;
      check_defaults("after_async");
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
